// File: rtl/ram_bus_arbiter_pkg.sv
// Shared definitions for the SRAM time-slot arbiter: frame geometry, slot
// encodings and the sub-phase helpers used by the sequencer and the arbiter.
package ram_bus_arbiter_pkg;

  localparam int FRAME_LEN = 16;
  localparam int PHASE_W   = $clog2(FRAME_LEN);

  typedef enum logic [1:0] {
    SLOT_VIDEO0 = 2'd0,
    SLOT_SPI    = 2'd1,
    SLOT_VIDEO1 = 2'd2,
    SLOT_CPU    = 2'd3
  } slot_e;

  // Sub-phase offsets within a 4-phase slot; PHASE_CPU_EN is an absolute phase.
  localparam logic [1:0]         PHASE_ADDR   = 2'd0;
  localparam logic [1:0]         PHASE_STROBE = 2'd2;
  localparam logic [PHASE_W-1:0] PHASE_CPU_EN = PHASE_W'(15);
  localparam logic [PHASE_W-1:0] PHASE_STEP   = PHASE_W'(1);

  function automatic logic is_xfer_sub(input logic [1:0] sub);
    return (sub == 2'd1) || (sub == 2'd2);
  endfunction

endpackage

// File: rtl/ram_bus_arbiter_slot_sequencer.sv
// Free-running frame phase counter; exposes the phase, slot and sub-phase the
// arbiter is about to enter so every arbiter output can be registered.
module slot_sequencer
  import ram_bus_arbiter_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  output logic [PHASE_W-1:0] phase_nxt,
  output slot_e              slot_nxt,
  output logic [1:0]         sub_nxt
);

  logic [PHASE_W-1:0] phase_q, phase_d;

  always_comb begin
    phase_d = phase_q + PHASE_STEP;
  end

  // NOTE: state registers use non-blocking assignments only; the matching
  // _d value is computed with blocking assignments in always_comb.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) phase_q <= '0;
    else       phase_q <= phase_d;
  end

  assign phase_nxt = phase_d;
  assign slot_nxt  = slot_e'(phase_d[PHASE_W-1 -: 2]);
  assign sub_nxt   = phase_d[1:0];

endmodule

// File: rtl/ram_bus_arbiter.sv
// Shares the external SRAM bus between video, SPI bridge and 6502 CPU using a
// fixed 16-clock frame of four 4-phase slots; all outputs are registered.
module ram_bus_arbiter
  import ram_bus_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = 17
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic                  cpu_we,
  input  logic                  cpu_ram_enable,
  input  logic                  cpu_is_readonly,
  input  logic [ADDR_WIDTH-1:0] video_addr,
  input  logic                  spi_req,
  input  logic [ADDR_WIDTH-1:0] spi_addr,
  input  logic                  spi_we,
  output logic                  spi_ack,
  output logic [ADDR_WIDTH-1:0] bus_addr,
  output logic                  ram_oe,
  output logic                  ram_we,
  output logic                  video_strobe,
  output logic                  cpu_strobe,
  output logic                  cpu_clk_en
);

  logic [PHASE_W-1:0] phase_nxt;
  slot_e              slot_nxt;
  logic [1:0]         sub_nxt;

  slot_sequencer u_seq (
    .clk       (clk),
    .reset     (reset),
    .phase_nxt (phase_nxt),
    .slot_nxt  (slot_nxt),
    .sub_nxt   (sub_nxt)
  );

  logic [ADDR_WIDTH-1:0] bus_addr_q, bus_addr_d;
  logic active_q, active_d;
  logic rd_q, rd_d;
  logic wr_q, wr_d;
  logic ram_oe_q, ram_oe_d;
  logic ram_we_q, ram_we_d;
  logic spi_ack_q, spi_ack_d;
  logic video_strobe_q, video_strobe_d;
  logic cpu_strobe_q, cpu_strobe_d;
  logic cpu_clk_en_q, cpu_clk_en_d;

  // Slot set-up: requester, direction and gating are latched on the edge
  // entering a slot, so mid-slot input changes cannot disturb the access.
  // NOTE: every variable gets a default before the case so no latch is inferred.
  always_comb begin
    bus_addr_d = bus_addr_q;
    active_d   = active_q;
    rd_d       = rd_q;
    wr_d       = wr_q;
    if (sub_nxt == PHASE_ADDR) begin
      unique case (slot_nxt)
        SLOT_VIDEO0, SLOT_VIDEO1: begin
          active_d   = 1'b1;
          rd_d       = 1'b1;
          wr_d       = 1'b0;
          bus_addr_d = video_addr;
        end
        SLOT_SPI: begin
          active_d = spi_req;
          rd_d     = spi_req && !spi_we;
          wr_d     = spi_req && spi_we;
          if (spi_req) bus_addr_d = spi_addr;
        end
        SLOT_CPU: begin
          active_d   = 1'b1;
          rd_d       = !cpu_we && cpu_ram_enable;
          wr_d       = cpu_we && cpu_ram_enable && !cpu_is_readonly;
          bus_addr_d = cpu_addr;
        end
      endcase
    end
  end

  // Output decode: rd_q and wr_q are mutually exclusive, so oe and we are too.
  always_comb begin
    ram_oe_d       = is_xfer_sub(sub_nxt) && rd_q;
    ram_we_d       = is_xfer_sub(sub_nxt) && wr_q;
    video_strobe_d = (sub_nxt == PHASE_STROBE) && active_q &&
                     ((slot_nxt == SLOT_VIDEO0) || (slot_nxt == SLOT_VIDEO1));
    spi_ack_d      = (sub_nxt == PHASE_STROBE) && active_q && (slot_nxt == SLOT_SPI);
    cpu_strobe_d   = (sub_nxt == PHASE_STROBE) && active_q && (slot_nxt == SLOT_CPU);
    cpu_clk_en_d   = (phase_nxt == PHASE_CPU_EN);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus_addr_q     <= '0;
      active_q       <= 1'b0;
      rd_q           <= 1'b0;
      wr_q           <= 1'b0;
      ram_oe_q       <= 1'b0;
      ram_we_q       <= 1'b0;
      spi_ack_q      <= 1'b0;
      video_strobe_q <= 1'b0;
      cpu_strobe_q   <= 1'b0;
      cpu_clk_en_q   <= 1'b0;
    end else begin
      bus_addr_q     <= bus_addr_d;
      active_q       <= active_d;
      rd_q           <= rd_d;
      wr_q           <= wr_d;
      ram_oe_q       <= ram_oe_d;
      ram_we_q       <= ram_we_d;
      spi_ack_q      <= spi_ack_d;
      video_strobe_q <= video_strobe_d;
      cpu_strobe_q   <= cpu_strobe_d;
      cpu_clk_en_q   <= cpu_clk_en_d;
    end
  end

  assign bus_addr     = bus_addr_q;
  assign ram_oe       = ram_oe_q;
  assign ram_we       = ram_we_q;
  assign spi_ack      = spi_ack_q;
  assign video_strobe = video_strobe_q;
  assign cpu_strobe   = cpu_strobe_q;
  assign cpu_clk_en   = cpu_clk_en_q;

endmodule

// File: tb/tb_ram_bus_arbiter.sv
// Self-checking bench for ram_bus_arbiter: reset values, free-run frame timing,
// SPI handshake scoreboard, CPU gating table, reset mid-access and random frames.
module tb_ram_bus_arbiter;

  localparam int AW = 17;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [AW-1:0] cpu_addr = '0;
  logic          cpu_we = 1'b0;
  logic          cpu_ram_enable = 1'b0;
  logic          cpu_is_readonly = 1'b0;
  logic [AW-1:0] video_addr = '0;
  logic          spi_req = 1'b0;
  logic [AW-1:0] spi_addr = '0;
  logic          spi_we = 1'b0;
  logic          spi_ack;
  logic [AW-1:0] bus_addr;
  logic          ram_oe;
  logic          ram_we;
  logic          video_strobe;
  logic          cpu_strobe;
  logic          cpu_clk_en;

  ram_bus_arbiter #(.ADDR_WIDTH(AW)) dut (
    .clk             (clk),
    .reset           (reset),
    .cpu_addr        (cpu_addr),
    .cpu_we          (cpu_we),
    .cpu_ram_enable  (cpu_ram_enable),
    .cpu_is_readonly (cpu_is_readonly),
    .video_addr      (video_addr),
    .spi_req         (spi_req),
    .spi_addr        (spi_addr),
    .spi_we          (spi_we),
    .spi_ack         (spi_ack),
    .bus_addr        (bus_addr),
    .ram_oe          (ram_oe),
    .ram_we          (ram_we),
    .video_strobe    (video_strobe),
    .cpu_strobe      (cpu_strobe),
    .cpu_clk_en      (cpu_clk_en)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
  } spi_exp_t;

  spi_exp_t   exp_q[$];
  logic [3:0] tb_phase = '0;
  int         tb_frame = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (phase %0d, t=%0t)", name, act, exp, tb_phase, $time);
    end
  endtask

  // Reference frame timing; also samples the SPI request on the edge entering phase 4.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      tb_phase <= '0;
      tb_frame <= 0;
      exp_q.delete();
    end else begin
      if (tb_phase == 4'd3 && spi_req) exp_q.push_back({spi_we, spi_addr});
      tb_phase <= tb_phase + 4'd1;
      if (tb_phase == 4'd15) tb_frame <= tb_frame + 1;
    end
  end

  // Continuous monitor: bus exclusion, CPU clock enable timing, SPI scoreboard.
  always @(negedge clk) begin
    if (!reset) begin
      check("oe_we_excl", {31'd0, ram_oe & ram_we}, 32'd0);
      check("cpu_clk_en", {31'd0, cpu_clk_en}, {31'd0, tb_phase == 4'd15});
      if (tb_phase == 4'd6) begin
        check("spi_ack_expected", {31'd0, spi_ack}, {31'd0, exp_q.size() != 0});
        if (spi_ack && exp_q.size() != 0) begin
          spi_exp_t e;
          e = exp_q.pop_front();
          check("spi_ack_addr", {15'd0, bus_addr}, {15'd0, e.addr});
          check("spi_ack_dir", {30'd0, ram_we, ram_oe}, e.we ? 32'd2 : 32'd1);
        end
      end else begin
        check("spi_ack_offphase", {31'd0, spi_ack}, 32'd0);
      end
    end
  end

  task automatic wait_phase(input int p);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (tb_phase != 4'(p) && n < 17);
    check("wait_phase", {28'd0, tb_phase}, 32'(p));
  endtask

  typedef struct {
    logic [AW-1:0] addr;
    logic          we;
    logic          ram_en;
    logic          ro;
    logic          exp_oe;
    logic          exp_we;
  } cpu_vec_t;

  cpu_vec_t cpu_vecs[6];

  initial begin
    int cen_count;
    int acks;
    int lat;

    cpu_vecs[0] = '{17'h00400, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    cpu_vecs[1] = '{17'h0C000, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    cpu_vecs[2] = '{17'h0E810, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    cpu_vecs[3] = '{17'h00400, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    cpu_vecs[4] = '{17'h1FFFF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    cpu_vecs[5] = '{17'h0C000, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};

    // Reset values
    video_addr = 17'h1ABCD;
    repeat (3) @(negedge clk);
    check("rst_bus_addr", {15'd0, bus_addr}, 32'd0);
    check("rst_oe", {31'd0, ram_oe}, 32'd0);
    check("rst_we", {31'd0, ram_we}, 32'd0);
    check("rst_ack", {31'd0, spi_ack}, 32'd0);
    check("rst_vstrobe", {31'd0, video_strobe}, 32'd0);
    check("rst_cstrobe", {31'd0, cpu_strobe}, 32'd0);
    check("rst_cen", {31'd0, cpu_clk_en}, 32'd0);
    reset = 1'b0;

    // Free run: slot 0 idle in the first frame only
    cen_count = 0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      check("fr_oe", {31'd0, ram_oe},
            {31'd0, (tb_phase == 4'd9 || tb_phase == 4'd10) ||
                    ((tb_phase == 4'd1 || tb_phase == 4'd2) && tb_frame != 0)});
      check("fr_vstrobe", {31'd0, video_strobe},
            {31'd0, tb_phase == 4'd10 || (tb_phase == 4'd2 && tb_frame != 0)});
      if (tb_phase == 4'd5 && tb_frame == 0) check("fr_idle_addr", {15'd0, bus_addr}, 32'd0);
      if (tb_phase == 4'd8) check("fr_video_addr", {15'd0, bus_addr}, 32'h1ABCD);
      if (cpu_clk_en) cen_count++;
    end
    check("fr_cen_count", 32'(cen_count), 32'd4);

    // SPI best case, held for two frames
    wait_phase(0);
    spi_req = 1'b1; spi_addr = 17'h01234; spi_we = 1'b0;
    acks = 0;
    for (int f = 0; f < 2; f++) begin
      for (int p = 4; p <= 7; p++) begin
        wait_phase(p);
        check("spi_bus_addr", {15'd0, bus_addr}, 32'h01234);
        check("spi_oe", {31'd0, ram_oe}, {31'd0, p == 5 || p == 6});
        check("spi_we", {31'd0, ram_we}, 32'd0);
        if (spi_ack) acks++;
      end
    end
    spi_req = 1'b0;
    check("spi_two_acks", 32'(acks), 32'd2);

    // CPU gating table
    for (int v = 0; v < 6; v++) begin
      wait_phase(8);
      cpu_addr = cpu_vecs[v].addr; cpu_we = cpu_vecs[v].we;
      cpu_ram_enable = cpu_vecs[v].ram_en; cpu_is_readonly = cpu_vecs[v].ro;
      for (int p = 12; p <= 15; p++) begin
        wait_phase(p);
        check("cpu_bus_addr", {15'd0, bus_addr}, {15'd0, cpu_vecs[v].addr});
        check("cpu_oe", {31'd0, ram_oe}, {31'd0, cpu_vecs[v].exp_oe && (p == 13 || p == 14)});
        check("cpu_we", {31'd0, ram_we}, {31'd0, cpu_vecs[v].exp_we && (p == 13 || p == 14)});
        check("cpu_strobe", {31'd0, cpu_strobe}, {31'd0, p == 14});
      end
    end
    cpu_we = 1'b0; cpu_ram_enable = 1'b0; cpu_is_readonly = 1'b0;

    // SPI worst case: request rises just after the sampling edge
    wait_phase(4);
    spi_req = 1'b1; spi_addr = 17'h0BEEF; spi_we = 1'b1;
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (spi_ack && lat == 0) begin
        lat = k;
        check("late_we", {31'd0, ram_we}, 32'd1);
      end
    end
    spi_req = 1'b0;
    check("late_latency", 32'(lat), 32'd18);

    // Reset in the middle of an SPI access
    wait_phase(0);
    spi_req = 1'b1; spi_addr = 17'h1F00F; spi_we = 1'b0;
    wait_phase(5);
    check("mid_oe_before_rst", {31'd0, ram_oe}, 32'd1);
    reset = 1'b1;
    #1;
    check("mid_rst_bus_addr", {15'd0, bus_addr}, 32'd0);
    check("mid_rst_oe", {31'd0, ram_oe}, 32'd0);
    check("mid_rst_we", {31'd0, ram_we}, 32'd0);
    check("mid_rst_ack", {31'd0, spi_ack}, 32'd0);
    check("mid_rst_vstrobe", {31'd0, video_strobe}, 32'd0);
    check("mid_rst_cstrobe", {31'd0, cpu_strobe}, 32'd0);
    check("mid_rst_cen", {31'd0, cpu_clk_en}, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    lat = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (spi_ack && lat == 0) begin
        lat = k;
        check("post_rst_addr", {15'd0, bus_addr}, 32'h1F00F);
      end
    end
    spi_req = 1'b0;
    check("post_rst_latency", 32'(lat), 32'd6);

    // Random frames
    for (int fr = 0; fr < 1000; fr++) begin
      logic new_req;
      logic exp_oe, exp_we;
      wait_phase(8);
      cpu_addr = AW'($urandom); cpu_we = 1'($urandom);
      cpu_ram_enable = 1'($urandom); cpu_is_readonly = 1'($urandom);
      video_addr = AW'($urandom);
      exp_oe = !cpu_we && cpu_ram_enable;
      exp_we = cpu_we && cpu_ram_enable && !cpu_is_readonly;
      wait_phase(13);
      check("rnd_cpu_oe", {31'd0, ram_oe}, {31'd0, exp_oe});
      check("rnd_cpu_we", {31'd0, ram_we}, {31'd0, exp_we});
      wait_phase($urandom_range(0, 15));
      new_req = 1'($urandom_range(0, 1));
      if (new_req && !spi_req) begin
        spi_addr = AW'($urandom);
        spi_we = 1'($urandom);
      end
      spi_req = new_req;
    end
    spi_req = 1'b0;
    repeat (40) @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

endmodule
